// File: rtl/compuertas_pkg.sv
// Shared constants for the compuertas gate block: default build parameters
// and the reference S1/S2 truth tables indexed by {A,B,C}.
package compuertas_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam bit          REG_OUT_DEF     = 1'b1;

  // Bit i of each table is the result for input combination i = {A,B,C}.
  localparam logic [7:0] S1_TT = 8'b1110_1010;
  localparam logic [7:0] S2_TT = 8'b1001_0110;

  typedef struct packed {
    logic s1;
    logic s2;
  } gates_t;

  function automatic gates_t tt_lookup(input logic [2:0] abc);
    gates_t r;
    r.s1 = S1_TT[abc];
    r.s2 = S2_TT[abc];
    return r;
  endfunction

endpackage

// File: rtl/compuertas_sync.sv
// Single-bit synchronizer: STAGES flops in series, cleared by synchronous reset.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/compuertas.sv
// Synchronized AND-OR / XOR gate block; inputs are resynchronized before any
// logic and results are optionally registered.
module compuertas
  import compuertas_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter bit          REG_OUT     = REG_OUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic C,
  output logic S1,
  output logic S2
);

  logic as, bs, cs;
  gates_t comb_res;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .rst_n(rst_n), .d(A), .q(as));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .rst_n(rst_n), .d(B), .q(bs));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_c (.clk(clk), .rst_n(rst_n), .d(C), .q(cs));

  always_comb begin
    comb_res    = '0;
    comb_res.s1 = (as & bs) | cs;
    comb_res.s2 = as ^ bs ^ cs;
  end

  generate
    if (REG_OUT) begin : g_reg
      gates_t out_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_q <= '0;
        end else begin
          out_q <= comb_res;
        end
      end
      assign S1 = out_q.s1;
      assign S2 = out_q.s2;
    end else begin : g_comb
      // Still flop-driven only: the synchronizer outputs feed the gates.
      assign S1 = comb_res.s1;
      assign S2 = comb_res.s2;
    end
  endgenerate

endmodule

// File: tb/tb_compuertas.sv
// Directed and random checks of compuertas, registered and combinational builds.
module tb_compuertas;
  import compuertas_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic A, B, C;
  logic S1, S2, S1c, S2c;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  compuertas dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .S1(S1), .S2(S2)
  );

  compuertas #(.SYNC_STAGES(2), .REG_OUT(1'b0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .S1(S1c), .S2(S2c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v);
    {A, B, C} = v;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  logic [1:0] hand_tt [8];
  logic [2:0] seq [4];
  logic [1:0] seq_exp [4];
  logic [2:0] rnd [1000];
  gates_t     ref_g;

  initial begin
    // {S1,S2} for A B C = 000..111, computed by hand
    hand_tt[0] = 2'b00; hand_tt[1] = 2'b11; hand_tt[2] = 2'b01; hand_tt[3] = 2'b10;
    hand_tt[4] = 2'b01; hand_tt[5] = 2'b10; hand_tt[6] = 2'b10; hand_tt[7] = 2'b11;

    // Reset with all inputs high
    rst_n = 1'b0;
    drive(3'b111);
    step(); chk("rst_hold1", {S1, S2}, 2'b00); chk("rst_hold1_comb", {S1c, S2c}, 2'b00);
    step(); chk("rst_hold2", {S1, S2}, 2'b00); chk("rst_hold2_comb", {S1c, S2c}, 2'b00);
    rst_n = 1'b1;
    step(); chk("rel_e1", {S1, S2}, 2'b00);
    step(); chk("rel_e2", {S1, S2}, 2'b00); chk("rel_e2_comb", {S1c, S2c}, 2'b11);
    step(); chk("rel_e3", {S1, S2}, 2'b11);

    // Exhaustive sweep, each vector held 5 cycles
    for (int v = 0; v < 8; v++) begin
      drive(3'(v));
      step();
      step(); chk($sformatf("sweep_comb_%0d", v), {S1c, S2c}, hand_tt[v]);
      step(); chk($sformatf("sweep_%0d", v), {S1, S2}, hand_tt[v]);
      step();
      step(); chk($sformatf("sweep_hold_%0d", v), {S1, S2}, hand_tt[v]);
    end

    // Back-to-back vectors on consecutive cycles
    seq[0] = 3'b000; seq[1] = 3'b011; seq[2] = 3'b101; seq[3] = 3'b111;
    seq_exp[0] = 2'b00; seq_exp[1] = 2'b10; seq_exp[2] = 2'b10; seq_exp[3] = 2'b11;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(seq[i]);
      step();
      if (i >= 2 && i < 6) chk($sformatf("b2b_%0d", i - 2), {S1, S2}, seq_exp[i-2]);
      if (i >= 1 && i < 5) chk($sformatf("b2b_comb_%0d", i - 1), {S1c, S2c}, seq_exp[i-1]);
    end

    // Settle on 000, then reset mid-stream while 111 is in flight
    drive(3'b000);
    repeat (4) step();
    chk("pre_mid", {S1, S2}, 2'b00);
    drive(3'b111);
    step(); chk("mid_e1", {S1, S2}, 2'b00);
    step(); chk("mid_e2", {S1, S2}, 2'b00);
    rst_n = 1'b0;
    step(); chk("mid_rst", {S1, S2}, 2'b00); chk("mid_rst_comb", {S1c, S2c}, 2'b00);
    rst_n = 1'b1;
    step(); chk("mid_rel1", {S1, S2}, 2'b00); chk("mid_rel1_comb", {S1c, S2c}, 2'b00);
    step(); chk("mid_rel2", {S1, S2}, 2'b00);
    step(); chk("mid_rel3", {S1, S2}, 2'b11);

    // REG_OUT=0 build: 001 visible after exactly 2 edges
    drive(3'b000);
    repeat (4) step();
    drive(3'b001);
    step(); chk("comb_001_e1", {S1c, S2c}, 2'b00);
    step(); chk("comb_001_e2", {S1c, S2c}, 2'b11);

    // Random stress against delayed reference
    for (int i = 0; i < 1000; i++) begin
      rnd[i] = 3'($urandom_range(0, 7));
      drive(rnd[i]);
      step();
      if (i >= 2) begin
        ref_g = tt_lookup(rnd[i-2]);
        chk("rand", {S1, S2}, {ref_g.s1, ref_g.s2});
      end
      if (i >= 1) begin
        ref_g = tt_lookup(rnd[i-1]);
        chk("rand_comb", {S1c, S2c}, {ref_g.s1, ref_g.s2});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/compuertas.md
COMPUERTAS -- requirements
Module: compuertas

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops per input (legal 1..4).
REQ-002 Parameter: REG_OUT, default 1, 1 = outputs registered, 0 = outputs taken combinationally from the synchronized inputs.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 Port: A  input  1  asynchronous logic input A.
REQ-007 Port: B  input  1  asynchronous logic input B.
REQ-008 Port: C  input  1  asynchronous logic input C.
REQ-009 Port: S1  output  1  gate result S1 = (A AND B) OR C.
REQ-010 Port: S2  output  1  gate result S2 = A XOR B XOR C (odd parity).

Function
REQ-011 Each input SHALL pass through its own SYNC_STAGES-deep flop chain before any logic; synchronized values are As, Bs, Cs.
REQ-012 S1 SHALL equal (As AND Bs) OR Cs.
REQ-013 S2 SHALL equal As XOR Bs XOR Cs.
REQ-014 Truth table (A B C -> S1 S2): 000->0 0, 001->1 1, 010->0 1, 011->1 0, 100->0 1, 101->1 0, 110->1 0, 111->1 1.
REQ-015 With REG_OUT=1, S1/S2 SHALL be registered; input-to-output latency SHALL be SYNC_STAGES+1 rising edges (3 at defaults).
REQ-016 With REG_OUT=0, latency SHALL be SYNC_STAGES rising edges; outputs SHALL depend only on flop outputs (no input-to-output combinational path).
REQ-017 No handshake; a new input combination SHALL be accepted every cycle, with outputs tracking inputs cycle-for-cycle after the latency.
REQ-018 Inputs changing on consecutive cycles SHALL produce each intermediate result for exactly one cycle, in order.
REQ-019 Simultaneous change of several inputs SHALL yield the new combination's result, with no partial-combination output, provided all changes meet setup on the same edge.
REQ-020 Outputs SHALL never be X/Z after the first reset edge.

Reset
REQ-021 While rst_n=0 at a rising edge, all synchronizer flops and output registers SHALL clear to 0.
REQ-022 Reset values: S1=0, S2=0 (equal to the 000 result).
REQ-023 After rst_n returns to 1, outputs SHALL reflect inputs after the normal latency; preceding cycles SHALL show 0.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight values; no pre-reset value SHALL appear after release.
REQ-025 Behaviour before the first reset edge is undefined.

Structure
REQ-026 Shared package compuertas_pkg SHALL hold SYNC_STAGES_DEF=2, REG_OUT_DEF=1, and the 8-entry expected S1/S2 truth-table constants for reuse by RTL and bench.
REQ-027 One sub-module, sync_bit (parameter STAGES, ports clk, rst_n, d, q), SHALL implement the per-input synchronizer, instantiated three times.
REQ-028 Gate logic SHALL be local combinational logic in compuertas; no latches.

Verification
REQ-029 Reset: rst_n=0 for 2 cycles with A=B=C=1 -> S1=0, S2=0 throughout reset and for 3 cycles after release, then S1=1, S2=1.
REQ-030 Exhaustive sweep: apply 000..111, each held 5 cycles -> after 3 edges S1/S2 match REQ-014 (e.g. 011 -> S1=1, S2=0; 101 -> S1=1, S2=0).
REQ-031 Back-to-back: 000, 011, 101, 111 on consecutive cycles -> S1,S2 = 00, 10, 10, 11 on consecutive cycles, starting 3 edges after the first vector.
REQ-032 Reset mid-operation: drive 111, assert rst_n=0 for 1 cycle after 2 edges -> S1/S2 stay 0 and show no 11 until 3 edges after release.
REQ-033 REG_OUT=0 build: drive 001 -> S1=1, S2=1 after exactly 2 edges.
REQ-034 Stress: 1000 random vectors, one per cycle -> outputs equal the 3-cycle-delayed reference model every cycle.
